relu_maxpool_2x2: RTL and testbench
===================================

// Module: relu_maxpool_2x2
// PURPOSE
// - Downstream stage of the 3x3 convolution: consumes its OFM stream (12x12 results, 36-bit signed,
//   raster order, one per in_valid) and produces a 6x6 map by 2x2 max pooling, stride 2.
// - Optional ReLU is applied to every pooled result before output.
// - Streaming; no backpressure, because the conv stage has none. Half-row line buffer only.
// PARAMETERS
// - DW     36  data width of OFM samples and of pooled outputs (signed two's complement)
// - IMG_W  12  OFM columns per row; must be even, >= 2
// - IMG_H  12  OFM rows per frame; must be even, >= 2
// PORTS
// - clk         in   1   single clock, rising edge
// - rst         in   1   asynchronous, active-high reset
// - in_valid    in   1   In_OFM valid this cycle; gaps (in_valid=0) allowed anywhere
// - In_OFM      in   DW  conv result, signed
// - out_valid   out  1   Out_Pool valid; registered, one-cycle pulse per pooled result
// - Out_Pool    out  DW  pooled (and optionally ReLU'd) result, signed; registered
// - frame_done  out  1   registered one-cycle pulse, together with the last pooled output of a frame
// BEHAVIOUR
// - Reset (async, rst=1): out_valid=0, Out_Pool=0, frame_done=0, col=0, row=0, pair_max=0.
//   Line buffer contents are not reset (don't-care, always written before being read).
// - Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted samples (in_valid=1).
//   col wraps to 0 at IMG_W-1 and row increments; row wraps to 0 at IMG_H-1 (next frame, no idle gap).
// - Even col: latch sample into pair_max register.
// - Odd col: h = signed max(pair_max, In_OFM) (combinational).
//   - Even row: linebuf[col>>1] <= h.
//   - Odd row: p = signed max(linebuf[col>>1], h); next cycle out_valid=1, Out_Pool=f(p).
// - Latency: out_valid is asserted on the cycle after the 4th sample of a window (odd row, odd col)
//   is accepted. One output per two accepted inputs on odd rows; none on even rows.
// - In other cycles out_valid=0; Out_Pool holds its last value.
// - frame_done=1 on the same cycle as the output for row=IMG_H-1, col=IMG_W-1; otherwise 0.
// - Ties: equal values give that value. Comparison is signed across the full DW, with no truncation.
// - Line buffer: IMG_W/2 entries x DW. An entry is written on an even row and read on the next odd
//   row; the same index is never read and written in the same cycle.
// - Back-to-back frames: the first sample of frame N+1 can arrive on the cycle after the last
//   sample of frame N. frame_done and the final output are still emitted the cycle after that.
// - Reset mid-frame: the partial frame is discarded with no output, and the next accepted sample
//   is treated as (row 0, col 0).
// - in_valid held high beyond IMG_W*IMG_H samples is a new frame (counters wrapped); not an error.
// CONFIGURATION
// - RELU_POOL_EN defined: f(p) = (p[DW-1]) ? 0 : p, so a negative pooled value outputs 0.
// - RELU_POOL_EN undefined: f(p) = p, so the signed max passes through unchanged.
// - ReLU is applied after pooling; the result is identical to ReLU-before-pool. The macro adds no
//   latency either way.
// TESTING
// - T1 reset: assert rst mid-stream -> out_valid=0, Out_Pool=0, frame_done=0 immediately (async).
//   After release, 144 samples give exactly 36 outputs.
// - T2 ramp: In_OFM = index 0..143, continuous in_valid -> outputs 13,15,...,23, 37,...,47, ...,
//   133,...,143 (bottom-right of each window). frame_done coincides with the output of value 143.
// - T3 signed/ReLU: window {-5,-9,-2,-7} -> with RELU_POOL_EN Out_Pool=0; without, Out_Pool=-2.
//   Window {-1, 2^34, 0, 3} -> 2^34 in both builds.
// - T4 gaps: random in_valid=0 bubbles (~30%) with the T2 data -> the same 36 values in the same
//   order. Each output comes the cycle after its 4th sample is accepted.
// - T5 back-to-back: two frames with no gap, frame2 = frame1 negated -> 72 outputs and 2
//   frame_done pulses. Frame2 outputs are all 0 under RELU_POOL_EN.
// - T6 extremes: windows of all 0x7_FFFF_FFFF and all 0x8_0000_0000 (most negative) -> the correct
//   signed max with no wrap. Under ReLU the most-negative window gives 0.

Source files
------------

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: 2x2 max pooling (stride 2) over a raster-order OFM stream,
// followed by an optional ReLU on each pooled result.
// Build option: define RELU_POOL_EN to clamp negative pooled values to zero.
module relu_maxpool_2x2 #(
    parameter int unsigned DW    = 36,
    parameter int unsigned IMG_W = 12,
    parameter int unsigned IMG_H = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] In_OFM,
    output logic          out_valid,
    output logic [DW-1:0] Out_Pool,
    output logic          frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_N  = IMG_W / 2;
    localparam int unsigned LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic signed [DW-1:0] pair_max_q, pair_max_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_pool_q, out_pool_d;
    logic                 frame_done_q, frame_done_d;

    // Half-row buffer of horizontal pair maxima; written on even rows, read on odd rows
    logic signed [DW-1:0] linebuf_q [LB_N];
    logic                 lb_we;
    logic [LB_AW-1:0]     lb_idx;

    logic signed [DW-1:0] in_s;
    logic signed [DW-1:0] h_max;
    logic signed [DW-1:0] lb_rd;
    logic signed [DW-1:0] p_max;
    logic signed [DW-1:0] f_p;
    logic                 last_col;
    logic                 last_row;

    // Pooling datapath: horizontal pair max, vertical max against line buffer, optional ReLU
    always_comb begin
        in_s     = $signed(In_OFM);
        lb_idx   = LB_AW'(col_q >> 1);
        h_max    = (pair_max_q > in_s) ? pair_max_q : in_s;
        lb_rd    = linebuf_q[lb_idx];
        p_max    = (lb_rd > h_max) ? lb_rd : h_max;
`ifdef RELU_POOL_EN
        f_p      = p_max[DW-1] ? '0 : p_max;
`else
        f_p      = p_max;
`endif
        last_col = (col_q == COL_W'(IMG_W - 1));
        last_row = (row_q == ROW_W'(IMG_H - 1));
    end

    // Next-state: raster counters, pair latch, line-buffer write enable, output staging
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_max_d   = pair_max_q;
        out_valid_d  = 1'b0;
        out_pool_d   = out_pool_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (in_valid) begin
            if (!col_q[0]) begin
                pair_max_d = in_s;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_pool_d   = f_p;
                frame_done_d = last_row && last_col;
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_max_q   <= '0;
            out_valid_q  <= 1'b0;
            out_pool_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_max_q   <= pair_max_d;
            out_valid_q  <= out_valid_d;
            out_pool_q   <= out_pool_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer storage; contents need no reset since every entry is written before it is read
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= h_max;
        end
    end

    assign out_valid  = out_valid_q;
    assign Out_Pool   = out_pool_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench for relu_maxpool_2x2: the driver pushes the expected pooled value,
// frame_done flag and arrival cycle when a window's 4th sample is driven; a monitor pops and compares.
module tb_relu_maxpool_2x2;

    localparam int DW = 36;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int N  = W * H;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          out_valid;
    logic [DW-1:0] Out_Pool;
    logic          frame_done;

    relu_maxpool_2x2 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .In_OFM     (In_OFM),
        .out_valid  (out_valid),
        .Out_Pool   (Out_Pool),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fd;
        logic [31:0]   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    int   n_fd   = 0;
    logic [DW-1:0] last_data = '0;

    logic signed [DW-1:0] img   [H][W];
    logic signed [DW-1:0] frame [N];
    int tb_row = 0;
    int tb_col = 0;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] a);
`ifdef RELU_POOL_EN
        return (a < 0) ? '0 : a;
`else
        return a;
`endif
    endfunction

    // Drive one sample; on a window's 4th sample push the expected result for the next edge
    task automatic send(input logic signed [DW-1:0] v);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        In_OFM   = v;
        img[tb_row][tb_col] = v;
        if ((tb_row % 2 == 1) && (tb_col % 2 == 1)) begin
            e.data = relu(smax(smax(img[tb_row-1][tb_col-1], img[tb_row-1][tb_col]),
                               smax(img[tb_row][tb_col-1], v)));
            e.fd   = (tb_row == H - 1) && (tb_col == W - 1);
            e.cyc  = 32'(cyc + 1);
            sb.push_back(e);
        end
        if (tb_col == W - 1) begin
            tb_col = 0;
            tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
        end else begin
            tb_col = tb_col + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            In_OFM   = {$urandom, $urandom};
        end
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < N; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
            send(frame[i]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every out_valid, check Out_Pool holds otherwise
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            if (out_valid) begin
                n_out++;
                if (frame_done) n_fd++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got Out_Pool=%0d at cycle %0d, expected no output",
                             $signed(Out_Pool), cyc);
                end else begin
                    e = sb.pop_front();
                    last_data = e.data;
                    if (Out_Pool !== e.data || frame_done !== e.fd || cyc != int'(e.cyc)) begin
                        errors++;
                        $display("FAIL pool_output: got data=%0d fd=%b cyc=%0d, expected data=%0d fd=%b cyc=%0d",
                                 $signed(Out_Pool), frame_done, cyc, $signed(e.data), e.fd, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0 || Out_Pool !== last_data) begin
                    errors++;
                    $display("FAIL idle_hold: got fd=%b Out_Pool=%0d, expected fd=0 Out_Pool=%0d",
                             frame_done, $signed(Out_Pool), $signed(last_data));
                end
            end
        end
    end

    initial begin
        int out0;
        int fd0;
        rst      = 1'b1;
        in_valid = 1'b0;
        In_OFM   = '0;
        repeat (2) @(negedge clk);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_out_pool", int'(Out_Pool != '0), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;

        // Ramp frame used by several tests
        for (int i = 0; i < N; i++) frame[i] = DW'(i);

        // T1: partial frame then asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) send(frame[i]);
        @(negedge clk);
        in_valid = 1'b0;
        check_int("pre_reset_value", int'(Out_Pool), 19);
        #1 rst = 1'b1;
        #1;
        check_int("async_rst_out_valid", int'(out_valid), 0);
        check_int("async_rst_out_pool", int'(Out_Pool != '0), 0);
        check_int("async_rst_frame_done", int'(frame_done), 0);
        check_int("partial_frame_drained", sb.size(), 0);
        tb_row    = 0;
        tb_col    = 0;
        last_data = '0;
        @(negedge clk);
        rst = 1'b0;

        // T2: continuous ramp -> 36 outputs, bottom-right of each window
        out0 = n_out;
        fd0  = n_fd;
        send_frame(0);
        idle(3);
        check_int("ramp_out_count", n_out - out0, 36);
        check_int("ramp_fd_count", n_fd - fd0, 1);
        check_int("ramp_last_value", int'(Out_Pool), 143);

        // T3/T6: signed windows, extremes, ties
        for (int i = 0; i < N; i++) frame[i] = DW'(((i * 37) % 101) - 50);
        frame[0]  = -36'sd5;            frame[1]  = -36'sd9;
        frame[12] = -36'sd2;            frame[13] = -36'sd7;
        frame[2]  = -36'sd1;            frame[3]  = 36'sd17179869184;
        frame[14] = 36'sd0;             frame[15] = 36'sd3;
        frame[4]  = 36'h7_FFFF_FFFF;    frame[5]  = 36'h7_FFFF_FFFF;
        frame[16] = 36'h7_FFFF_FFFF;    frame[17] = 36'h7_FFFF_FFFF;
        frame[6]  = 36'h8_0000_0000;    frame[7]  = 36'h8_0000_0000;
        frame[18] = 36'h8_0000_0000;    frame[19] = 36'h8_0000_0000;
        frame[8]  = 36'h8_0000_0000;    frame[9]  = 36'h7_FFFF_FFFF;
        frame[20] = 36'h8_0000_0000;    frame[21] = 36'h8_0000_0000;
        frame[10] = 36'sd7;             frame[11] = 36'sd7;
        frame[22] = 36'sd7;             frame[23] = 36'sd7;
        out0 = n_out;
        for (int i = 0; i < 14; i++) send(frame[i]);
        idle(2);
`ifdef RELU_POOL_EN
        check_int("neg_window_relu", int'(Out_Pool != '0), 0);
`else
        check_int("neg_window_plain", int'(Out_Pool == DW'(-36'sd2)), 1);
`endif
        for (int i = 14; i < 16; i++) send(frame[i]);
        idle(2);
        check_int("big_window", int'(Out_Pool == 36'd17179869184), 1);
        for (int i = 16; i < N; i++) send(frame[i]);
        idle(3);
        check_int("signed_out_count", n_out - out0, 36);

        // T4: ramp with ~30% bubbles
        for (int i = 0; i < N; i++) frame[i] = DW'(i);
        out0 = n_out;
        send_frame(30);
        idle(3);
        check_int("gap_out_count", n_out - out0, 36);

        // T5: two frames back to back, second negated
        out0 = n_out;
        fd0  = n_fd;
        for (int i = 0; i < N; i++) frame[i] = DW'(i * 1000 + 5);
        send_frame(0);
        for (int i = 0; i < N; i++) frame[i] = DW'(-(i * 1000 + 5));
        send_frame(0);
        idle(4);
        check_int("b2b_out_count", n_out - out0, 72);
        check_int("b2b_fd_count", n_fd - fd0, 2);

        idle(4);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
